// File: rtl/adder_sub_arbiter_if.sv
// ---------------------------------------------------------------------------
// adder_sub_arbiter_if
//   Bundles the two request channels, the shared adder_sub datapath link and
//   the tagged response channel of adder_sub_arbiter.
//
//   slave  : the arbiter's view. It takes the requests, drives the datapath
//            operands and produces the response.
//   master : the environment's view. It holds the requesters, the adder_sub
//            instance and the response consumer.
//
//   Signals
//     reqN_valid / reqN_ready   request handshake, N = 0/1
//     reqN_a / reqN_b           operands
//     reqN_mode                 0 = a+b, 1 = a-b
//     alu_a / alu_b / alu_ctrl  to the shared adder_sub
//     alu_out / alu_cout        from the shared adder_sub
//     rsp_valid / rsp_ready     response handshake
//     rsp_id                    requester that owns the result
//     rsp_data / rsp_cout       registered datapath result
//     busy                      arbiter is not idle
// ---------------------------------------------------------------------------
interface adder_sub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_mode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_mode;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_cout;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_mode,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_mode,
        output req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_out, alu_cout,
        output rsp_valid, rsp_id, rsp_data, rsp_cout,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_mode,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_mode,
        input  req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_out, alu_cout,
        input  rsp_valid, rsp_id, rsp_data, rsp_cout,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/adder_sub_arbiter.sv
// ---------------------------------------------------------------------------
// adder_sub_arbiter
//   Shares one combinational adder_sub between two requesters. A round-robin
//   grant picks one pending operation, the operands are presented to the
//   adder_sub for one cycle, the result is registered and handed back on a
//   valid/ready response channel tagged with the requester id.
//
//   Ports
//     clk   in   rising-edge clock for all state
//     rst   in   synchronous, active-high reset
//     bus   slave modport of adder_sub_arbiter_if (requests, datapath link,
//                response, busy)
//
//   State    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for a request; ready goes to the round-robin winner
//   ST_ISSUE | operand register drives the adder_sub; result captured at end
//   ST_RESP  | response held until the consumer takes it
// ---------------------------------------------------------------------------
module adder_sub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_sub_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic             last_grant_q, last_grant_d;

    logic [WIDTH-1:0] op_a_q,       op_a_d;
    logic [WIDTH-1:0] op_b_q,       op_b_d;
    logic             op_mode_q,    op_mode_d;
    logic             op_id_q,      op_id_d;

    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic             rsp_cout_q,   rsp_cout_d;

    logic             grant_id;
    logic             ready0;
    logic             ready1;
    logic             accept;

    // Round-robin winner. Only meaningful when at least one request is valid;
    // on a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Ready is qualified by the requester's own valid, so at most one of the
    // two can be high in any cycle.
    assign ready0 = (state_q == ST_IDLE) && bus.req0_valid && (grant_id == 1'b0);
    assign ready1 = (state_q == ST_IDLE) && bus.req1_valid && (grant_id == 1'b1);
    assign accept = ready0 | ready1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_mode_d    = op_mode_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_cout_d   = rsp_cout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_a_d       = grant_id ? bus.req1_a    : bus.req0_a;
                    op_b_d       = grant_id ? bus.req1_b    : bus.req0_b;
                    op_mode_d    = grant_id ? bus.req1_mode : bus.req0_mode;
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                rsp_data_d  = bus.alu_out;
                rsp_cout_d  = bus.alu_cout;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_mode_q    <= 1'b0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_mode_q    <= op_mode_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    // The operand register feeds the adder_sub directly: it only changes on
    // acceptance, so the datapath inputs are stable through ST_ISSUE and keep
    // their last value everywhere else.
    assign bus.alu_a      = op_a_q;
    assign bus.alu_b      = op_b_q;
    assign bus.alu_ctrl   = op_mode_q;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_cout   = rsp_cout_q;

    assign bus.busy       = (state_q != ST_IDLE);

endmodule
